// File: rtl/cpu_pkg.sv
// Shared datapath constants and the byte type used by the operand-select muxes.
package cpu_pkg;
  localparam int WIDTH = 8;
  localparam int SEL_W = 4;

  typedef logic [WIDTH-1:0] data_t;
endpackage

// File: rtl/mux_4x8.sv
// 4:1 byte selector, the leaf of the 16:1 select tree.
module mux_4x8
  import cpu_pkg::*;
(
  input  data_t      d0,
  input  data_t      d1,
  input  data_t      d2,
  input  data_t      d3,
  input  logic [1:0] sel,
  output data_t      y
);

  // Ternary form lets an unknown select bit propagate as X instead of a default.
  assign y = sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0);

endmodule

// File: rtl/mux_16x8.sv
// 16:1 byte selector with a combinational output and a registered copy.
module mux_16x8
  import cpu_pkg::*;
#(
  parameter int WIDTH  = cpu_pkg::WIDTH,
  parameter int NUM_IN = 16,
  parameter int SEL_W  = cpu_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [WIDTH-1:0] in8,
  input  logic [WIDTH-1:0] in9,
  input  logic [WIDTH-1:0] in10,
  input  logic [WIDTH-1:0] in11,
  input  logic [WIDTH-1:0] in12,
  input  logic [WIDTH-1:0] in13,
  input  logic [WIDTH-1:0] in14,
  input  logic [WIDTH-1:0] in15,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q
);

  data_t            grp   [NUM_IN/4];
  logic [WIDTH-1:0] y_d;

  // First level resolves sel[1:0] within each group of four inputs.
  mux_4x8 u_grp0 (.d0(in0),  .d1(in1),  .d2(in2),  .d3(in3),  .sel(sel[1:0]), .y(grp[0]));
  mux_4x8 u_grp1 (.d0(in4),  .d1(in5),  .d2(in6),  .d3(in7),  .sel(sel[1:0]), .y(grp[1]));
  mux_4x8 u_grp2 (.d0(in8),  .d1(in9),  .d2(in10), .d3(in11), .sel(sel[1:0]), .y(grp[2]));
  mux_4x8 u_grp3 (.d0(in12), .d1(in13), .d2(in14), .d3(in15), .sel(sel[1:0]), .y(grp[3]));

  // Second level picks the group with sel[3:2].
  mux_4x8 u_top (
    .d0 (grp[0]),
    .d1 (grp[1]),
    .d2 (grp[2]),
    .d3 (grp[3]),
    .sel(sel[3:2]),
    .y  (y)
  );

  always_comb begin
    y_d = y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

endmodule

// File: tb/tb_mux_16x8.sv
// Self-checking bench for mux_16x8: directed selection/reset cases plus a random scoreboard run.
module tb_mux_16x8;
  logic       clk;
  logic       rst;
  logic [7:0] din [16];
  logic [3:0] sel;
  logic [7:0] y;
  logic [7:0] y_q;

  int total;
  int bad;
  logic [7:0] sb [$];

  mux_16x8 dut (
    .clk (clk),
    .rst (rst),
    .in0 (din[0]),  .in1 (din[1]),  .in2 (din[2]),  .in3 (din[3]),
    .in4 (din[4]),  .in5 (din[5]),  .in6 (din[6]),  .in7 (din[7]),
    .in8 (din[8]),  .in9 (din[9]),  .in10(din[10]), .in11(din[11]),
    .in12(din[12]), .in13(din[13]), .in14(din[14]), .in15(din[15]),
    .sel (sel),
    .y   (y),
    .y_q (y_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model(input logic [3:0] s);
    return din[s];
  endfunction

  initial begin
    logic [7:0] e;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    sel   = 4'd0;
    for (int k = 0; k < 16; k++) din[k] = 8'h00;
    #1;
    chk("reset_yq", y_q, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Sweep every select code over the K*0x11 pattern.
    for (int k = 0; k < 16; k++) din[k] = 8'(k * 8'h11);
    for (int k = 0; k < 16; k++) begin
      sel = 4'(k);
      sb.push_back(8'(k * 8'h11));
      #10;
      chk($sformatf("sweep_sel%0d", k), y, sb.pop_front());
    end

    // Non-selected inputs must not disturb y.
    sel = 4'hA;
    for (int i = 0; i < 6; i++) begin
      din[3]  = 8'($urandom);
      din[11] = 8'($urandom);
      #1;
      chk("unsel_hold", y, 8'hAA);
    end
    din[10] = 8'h3C;
    #1;
    chk("sel_in_change", y, 8'h3C);
    din[3]  = 8'h33;
    din[11] = 8'hBB;
    din[10] = 8'hAA;

    // Reset held with clock running.
    @(negedge clk);
    rst = 1'b1;
    sel = 4'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_yq", y_q, 8'h00);
      chk("rst_hold_y", y, 8'h77);
    end
    rst = 1'b0;
    #1;
    chk("rst_rel_yq", y_q, 8'h00);
    @(posedge clk);
    #1;
    chk("rst_rel_load", y_q, 8'h77);

    // Select change just before and exactly at the edge.
    @(negedge clk);
    sel = 4'd2;
    @(posedge clk);
    #1;
    chk("edge_pre22", y_q, 8'h22);
    @(negedge clk);
    #4;
    sel = 4'd9;
    @(posedge clk);
    #1;
    chk("edge_late99", y_q, 8'h99);
    @(negedge clk);
    sel = 4'd2;
    @(posedge clk);
    #1;
    chk("edge_setup22", y_q, 8'h22);
    @(posedge clk);
    sel <= 4'd9;
    #1;
    chk("edge_same_yq", y_q, 8'h22);
    chk("edge_same_y", y, 8'h99);
    @(posedge clk);
    #1;
    chk("edge_next99", y_q, 8'h99);

    // Asynchronous reset mid-cycle.
    @(negedge clk);
    sel = 4'd14;
    @(posedge clk);
    #1;
    chk("async_pre", y_q, 8'hEE);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", y_q, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Random run: y checked each cycle, y_q against the previous cycle's y.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (sb.size() > 0) chk("rand_yq", y_q, sb.pop_front());
      for (int k = 0; k < 16; k++) din[k] = 8'($urandom);
      sel = 4'($urandom_range(15, 0));
      e = model(sel);
      #1;
      chk("rand_y", y, e);
      sb.push_back(e);
    end
    @(negedge clk);
    if (sb.size() > 0) chk("rand_yq_last", y_q, sb.pop_front());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
